// File: rtl/jkff_checker_if.sv
// rtl/jkff_checker_if.sv - bundle of monitored JK DUT signals and checker results
//
// master: drives DUT stimulus copies (dut_rst/j/k), DUT outputs (q_sr/q_d/q_t),
//         chk_en and clr; observes checker results.
// slave : the checker; samples the above and drives armed, exp_q, mismatch,
//         err_sticky, err_cnt, chk_cnt.
interface jkff_checker_if #(
  parameter int CNT_W = 8
);
  logic             dut_rst;
  logic             j;
  logic             k;
  logic             q_sr;
  logic             q_d;
  logic             q_t;
  logic             chk_en;
  logic             clr;
  logic             armed;
  logic             exp_q;
  logic [2:0]       mismatch;
  logic [2:0]       err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;

  modport master (
    output dut_rst, j, k, q_sr, q_d, q_t, chk_en, clr,
    input  armed, exp_q, mismatch, err_sticky, err_cnt, chk_cnt
  );

  modport slave (
    input  dut_rst, j, k, q_sr, q_d, q_t, chk_en, clr,
    output armed, exp_q, mismatch, err_sticky, err_cnt, chk_cnt
  );
endinterface

// File: rtl/jkff_checker.sv
// rtl/jkff_checker.sv - self-checking monitor for the SR/D/T-based JK flip-flop
//
// Ports:
//   clk   : clock, everything sampled on the rising edge
//   reset : asynchronous active-low reset of the checker
//   bus   : jkff_checker_if.slave
//           in : dut_rst (DUT reset, active-high), j, k, q_sr, q_d, q_t,
//                chk_en (compare this cycle), clr (sync clear of counters/flags)
//           out: armed, exp_q (reference state), mismatch {t,d,sr} pulse,
//                err_sticky {t,d,sr}, err_cnt, chk_cnt (saturating)
module jkff_checker #(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  jkff_checker_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             armed_r;
  logic             exp_q_r;
  logic [2:0]       mismatch_r;
  logic [2:0]       err_sticky_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] chk_cnt_r;

  logic [2:0]       cmp;
  logic             next_q;

  // DUT outputs seen at this edge were produced at the previous edge, which is
  // exactly what exp_q_r currently holds.
  assign cmp = {bus.q_t, bus.q_d, bus.q_sr} ^ {3{exp_q_r}};

  always_comb begin
    next_q = exp_q_r;
    if (bus.dut_rst) begin
      next_q = 1'b0;
    end else begin
      case ({bus.j, bus.k})
        2'b00:   next_q = exp_q_r;
        2'b01:   next_q = 1'b0;
        2'b10:   next_q = 1'b1;
        default: next_q = ~exp_q_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      armed_r      <= 1'b0;
      exp_q_r      <= 1'b0;
      mismatch_r   <= '0;
      err_sticky_r <= '0;
      err_cnt_r    <= '0;
      chk_cnt_r    <= '0;
    end else begin
      mismatch_r <= '0;
      if (state == IDLE) begin
        if (bus.dut_rst) begin
          state   <= CHECK;
          armed_r <= 1'b1;
          exp_q_r <= 1'b0;
        end
      end else begin
        if (bus.chk_en) begin
          mismatch_r   <= cmp;
          err_sticky_r <= err_sticky_r | cmp;
          // err_cnt only moves together with chk_cnt, so err_cnt <= chk_cnt holds
          if (chk_cnt_r != CNT_MAX) chk_cnt_r <= chk_cnt_r + 1'b1;
          if ((|cmp) && (err_cnt_r != CNT_MAX)) err_cnt_r <= err_cnt_r + 1'b1;
        end
        // The model tracks even with compares disabled, so no resync is needed.
        exp_q_r <= next_q;
      end
      // Last assignment wins: clr overrides this edge's increments and sticky set,
      // but leaves the mismatch pulse intact.
      if (bus.clr) begin
        err_sticky_r <= '0;
        err_cnt_r    <= '0;
        chk_cnt_r    <= '0;
      end
    end
  end

  assign bus.armed      = armed_r;
  assign bus.exp_q      = exp_q_r;
  assign bus.mismatch   = mismatch_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.chk_cnt    = chk_cnt_r;

endmodule
